button_ctrl_n: RTL and testbench

//  Parametrised front-panel controller: N debounced push-buttons with short/long press

---
 rtl/button_ctrl_n_if.sv | 38 +++
 rtl/button_ctrl_n.sv | 98 +++++++++
 tb/tb_button_ctrl_n.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/button_ctrl_n_if.sv
// button_ctrl_n_if: front-panel controller signal bundle
// Ports (slave = controller side):
//   i_btn            raw bouncing buttons, active-high
//   i_alarm_active   alarm currently ringing
//   o_btn_db         debounced levels
//   o_short_p        short-press release pulses
//   o_long_p         long-press pulses
//   o_mode           0=RUN 1=SET_T 2=SET_A
//   o_semnal_setare  mode==SET_T
//   o_semnal_setare_a mode==SET_A
//   o_semnal_stop    alarm-stop pulse
//   o_semnal_inc     increment pulse
//   o_semnal_dec     decrement pulse
//   o_led            mode!=RUN
interface button_ctrl_n_if #(parameter int N_BTN = 3);
    logic [N_BTN-1:0] i_btn;
    logic             i_alarm_active;
    logic [N_BTN-1:0] o_btn_db;
    logic [N_BTN-1:0] o_short_p;
    logic [N_BTN-1:0] o_long_p;
    logic [1:0]       o_mode;
    logic             o_semnal_setare;
    logic             o_semnal_setare_a;
    logic             o_semnal_stop;
    logic             o_semnal_inc;
    logic             o_semnal_dec;
    logic             o_led;
    modport slave (
        input  i_btn, i_alarm_active,
        output o_btn_db, o_short_p, o_long_p, o_mode, o_semnal_setare, o_semnal_setare_a,
               o_semnal_stop, o_semnal_inc, o_semnal_dec, o_led
    );
    modport master (
        output i_btn, i_alarm_active,
        input  o_btn_db, o_short_p, o_long_p, o_mode, o_semnal_setare, o_semnal_setare_a,
               o_semnal_stop, o_semnal_inc, o_semnal_dec, o_led
    );
endinterface

// File: rtl/button_ctrl_n.sv
// button_ctrl_n: N debounced buttons with short/long press detection driving the clock/alarm mode FSM
// Ports:
//   i_clock  system clock, rising edge
//   i_reset  synchronous active-high reset
//   bus      button_ctrl_n_if.slave: raw buttons/alarm in; debounced levels, press pulses,
//            mode and inc/dec/stop pulses out
module button_ctrl_n #(
    parameter int N_BTN       = 3,
    parameter int DEB_CYCLES  = 4,
    parameter int LONG_CYCLES = 16,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 8
) (
    input  logic            i_clock,
    input  logic            i_reset,
    button_ctrl_n_if.slave  bus
);
    typedef enum logic [1:0] {RUN = 2'd0, SET_T = 2'd1, SET_A = 2'd2} state_t;
    logic [N_BTN-1:0] r_s1, r_s2, r_db, r_short, r_long;
    logic [CNT_W-1:0] r_deb [N_BTN];
    logic [CNT_W-1:0] r_hold [N_BTN];
    logic [CNT_W-1:0] r_to, w_to;
    state_t           r_state, w_state;
    logic             r_stop, r_inc, r_dec, w_stop, w_inc, w_dec;
    logic             w_any, w_ev0, w_to_hit;
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_db    <= '0;
            r_short <= '0;
            r_long  <= '0;
            for (int c = 0; c < N_BTN; c++) begin
                r_deb[c]  <= '0;
                r_hold[c] <= '0;
            end
        end else begin
            r_s1 <= bus.i_btn;
            r_s2 <= r_s1;
            for (int c = 0; c < N_BTN; c++) begin
                if (r_s2[c] == r_db[c])
                    r_deb[c] <= '0;
                else if (r_deb[c] == CNT_W'(DEB_CYCLES-1)) begin
                    r_db[c]  <= r_s2[c];
                    r_deb[c] <= '0;
                end else
                    r_deb[c] <= r_deb[c] + CNT_W'(1);
                r_hold[c]  <= !r_db[c] ? '0 : r_hold[c] + CNT_W'(r_hold[c] < CNT_W'(LONG_CYCLES));
                r_long[c]  <= r_db[c] && r_hold[c] == CNT_W'(LONG_CYCLES-1);
                // hold is nonzero with the level low only in the cycle right after release
                r_short[c] <= !r_db[c] && r_hold[c] != '0 && r_hold[c] < CNT_W'(LONG_CYCLES);
            end
        end
    end
    always_comb begin
        w_state  = r_state;
        w_stop   = 1'b0;
        w_inc    = 1'b0;
        w_dec    = 1'b0;
        w_any    = |(r_short | r_long);
        w_ev0    = r_short[0] | r_long[0];
        w_to_hit = r_state != RUN && !w_any && r_to == CNT_W'(TIMEOUT-1);
        w_to     = (r_state == RUN || w_any || w_to_hit) ? '0 : r_to + CNT_W'(1);
        if (r_state == RUN) begin
            w_stop  = bus.i_alarm_active && w_any;
            w_state = (!w_stop && r_long[0]) ? SET_T : RUN;
        end else begin
            w_inc   = !w_ev0 && r_short[1] && !r_short[2];
            w_dec   = !w_ev0 && r_short[2] && !r_short[1];
            w_state = (r_state == SET_T && r_short[0]) ? SET_A : (w_ev0 || w_to_hit) ? RUN : r_state;
        end
    end
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= RUN;
            r_to    <= '0;
            r_stop  <= 1'b0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_to    <= w_to;
            r_stop  <= w_stop;
            r_inc   <= w_inc;
            r_dec   <= w_dec;
        end
    end
    assign bus.o_btn_db          = r_db;
    assign bus.o_short_p         = r_short;
    assign bus.o_long_p          = r_long;
    assign bus.o_mode            = r_state;
    assign bus.o_semnal_setare   = r_state == SET_T;
    assign bus.o_semnal_setare_a = r_state == SET_A;
    assign bus.o_led             = r_state != RUN;
    assign bus.o_semnal_stop     = r_stop;
    assign bus.o_semnal_inc      = r_inc;
    assign bus.o_semnal_dec      = r_dec;
endmodule

// File: tb/tb_button_ctrl_n.sv
// tb_button_ctrl_n: scoreboard bench for button_ctrl_n against a timeline reference model
module tb_button_ctrl_n;
    localparam int N = 4, DEB = 4, LONG = 16, TO = 64, MAXE = 8192;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    button_ctrl_n_if #(.N_BTN(N)) bus();
    button_ctrl_n #(.N_BTN(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .TIMEOUT(TO), .CNT_W(8))
        dut (.i_clock(clk), .i_reset(rst), .bus(bus));
    typedef struct packed {
        logic [N-1:0] db, sh, lg;
        logic [1:0]   mode;
        logic         st, sa, led, stop, inc, dec;
    } obs_t;
    typedef struct packed { int e; obs_t o; } rec_t;
    rec_t q[$];
    int checks = 0, errors = 0, cyc = 0;
    bit done = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    logic [N-1:0] hist [0:MAXE-1];
    int rst_e = 0, tlast = 0;
    int press_a [N];
    int fall_e [N];
    obs_t m = '0;
    function automatic logic samp(int idx, int c);
        return (idx <= rst_e) ? 1'b0 : hist[idx][c];
    endfunction
    // reference: levels change after DEB consecutive opposite synced samples; a press is
    // classified from its rise/fall edge times; mode follows the previous edge's events
    task automatic step(int e, logic [N-1:0] b, logic al, logic r);
        obs_t n;
        rec_t rc;
        logic any, ev0, win;
        if (e >= MAXE) begin
            $display("FAIL history_overflow edge %0d limit %0d", e, MAXE);
            $fatal(1);
        end
        n = '0;
        if (r) begin
            rst_e = e;
            tlast = e;
            for (int c = 0; c < N; c++) begin
                press_a[c] = -1000;
                fall_e[c]  = -1000;
            end
        end else begin
            hist[e] = b;
            any = |(m.sh | m.lg);
            ev0 = m.sh[0] | m.lg[0];
            n.mode = m.mode;
            if (m.mode == 2'd0) begin
                n.stop = al && any;
                if (!n.stop && m.lg[0]) n.mode = 2'd1;
                tlast = e;
            end else begin
                n.inc = !ev0 && m.sh[1] && !m.sh[2];
                n.dec = !ev0 && m.sh[2] && !m.sh[1];
                if (ev0) n.mode = (m.mode == 2'd1 && m.sh[0]) ? 2'd2 : 2'd0;
                if (any) tlast = e;
                else if (e - tlast == TO) begin
                    n.mode = 2'd0;
                    tlast  = e;
                end
            end
            n.db = m.db;
            for (int c = 0; c < N; c++) begin
                win = 1'b1;
                for (int k = 2; k <= DEB + 1; k++) if (samp(e - k, c) == m.db[c]) win = 1'b0;
                if (win) n.db[c] = ~m.db[c];
                n.lg[c] = m.db[c] && (e == press_a[c] + LONG);
                n.sh[c] = (e == fall_e[c] + 1) && (fall_e[c] - press_a[c] < LONG);
                if (!m.db[c] && n.db[c]) press_a[c] = e;
                if (m.db[c] && !n.db[c]) fall_e[c] = e;
            end
        end
        n.st  = n.mode == 2'd1;
        n.sa  = n.mode == 2'd2;
        n.led = n.mode != 2'd0;
        if (n != m || |{n.sh, n.lg, n.stop, n.inc, n.dec}) begin
            rc.e = e;
            rc.o = n;
            q.push_back(rc);
        end
        m = n;
    endtask
    function automatic obs_t sample_dut();
        obs_t o;
        o.db = bus.o_btn_db; o.sh = bus.o_short_p; o.lg = bus.o_long_p; o.mode = bus.o_mode;
        o.st = bus.o_semnal_setare; o.sa = bus.o_semnal_setare_a; o.led = bus.o_led;
        o.stop = bus.o_semnal_stop; o.inc = bus.o_semnal_inc; o.dec = bus.o_semnal_dec;
        return o;
    endfunction
    initial begin
        obs_t p, o;
        rec_t r;
        p = '0;
        forever begin
            @(negedge clk);
            if (!done) begin
                o = sample_dut();
                if (o !== p || |{o.sh, o.lg, o.stop, o.inc, o.dec}) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event edge %0d got %h", cyc, o);
                    end else begin
                        r = q.pop_front();
                        if (r.e != cyc || r.o !== o) begin
                            errors++;
                            $display("FAIL event edge %0d got %h required edge %0d value %h", cyc, o, r.e, r.o);
                        end
                    end
                end
                p = o;
            end
        end
    end
    task automatic tick(logic [N-1:0] b, logic al, logic r);
        bus.i_btn = b;
        bus.i_alarm_active = al;
        rst = r;
        step(cyc + 1, b, al, r);
        @(negedge clk);
    endtask
    task automatic press(logic [N-1:0] b, int len, logic al);
        repeat (len) tick(b, al, 1'b0);
        repeat (30) tick('0, al, 1'b0);
    endtask
    task automatic chk_zero(string nm);
        obs_t o;
        o = sample_dut();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL %s got %h required 0", nm, o);
        end
    endtask
    initial begin
        logic [N-1:0] b;
        int len;
        logic al;
        repeat (3) tick('0, 1'b0, 1'b1);
        chk_zero("reset_state");
        repeat (3) begin
            repeat (2) tick(4'b0001, 1'b0, 1'b0);
            repeat (2) tick(4'b0000, 1'b0, 1'b0);
        end
        press(4'b0001, 30, 1'b0);
        press(4'b0010, 10, 1'b0);
        press(4'b0001, 5, 1'b0);
        press(4'b0100, 10, 1'b0);
        press(4'b0001, 5, 1'b0);
        press(4'b0100, 10, 1'b1);
        press(4'b0001, 40, 1'b0);
        repeat (80) tick('0, 1'b0, 1'b0);
        press(4'b0001, 40, 1'b0);
        press(4'b0110, 10, 1'b0);
        press(4'b1000, 10, 1'b1);
        press(4'b0001, 40, 1'b0);
        repeat (15) tick(4'b0001, 1'b0, 1'b0);
        tick(4'b0001, 1'b0, 1'b1);
        chk_zero("reset_mid_hold");
        press(4'b0001, 40, 1'b0);
        repeat (70) begin
            b = ($urandom_range(0, 2) != 0) ? N'(1 << $urandom_range(0, N-1)) : N'($urandom_range(0, (1 << N) - 1));
            len = $urandom_range(1, 45);
            al = 1'($urandom_range(0, 1));
            repeat (len) tick(($urandom_range(0, 9) == 0) ? ~b : b, al, $urandom_range(0, 299) == 0);
            repeat ($urandom_range(0, 30)) tick('0, al, 1'b0);
        end
        repeat (40) tick('0, 1'b0, 1'b0);
        #1 done = 1'b1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
